seq_detector_param_moore: RTL

Parametrised, run-time programmable serial pattern detector with a Moore output. It generalises the fixed "111" Moore detector in five ways:
- configurable pattern length up to MAX_LEN bits;
- loadable pattern;
- overlap or non-overlap mode;
- input-valid qualifier;
- saturating match counter.
It sits on a 1-bit serial stream and flags each complete pattern occurrence one cycle after the last bit is sampled.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_det_sat_cnt.sv | 27 ++
 rtl/seq_detector_param_moore.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
// Pattern storage is sized by the top; helpers work at the 32-bit ceiling.
package seq_det_pkg;

  localparam int          PKG_DEF_LEN = 3;
  localparam logic [31:0] PKG_DEF_PAT = 32'b111;

  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Ones in bits [len-1:0]; callers cast down to their pattern width.
  function automatic logic [31:0] len_mask(input int len);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter; clear wins over a same-cycle increment.
// Count visible one cycle after the increment request.
module seq_det_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param_moore.sv
// Run-time programmable serial pattern detector with registered Moore match flag.
// Match flag rises one cycle after the last pattern bit is sampled; i_x_vld gates sampling.
module seq_detector_param_moore
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN = 8,
  parameter int                 CNT_W   = 8,
  parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(PKG_DEF_PAT),
  parameter int                 DEF_LEN = PKG_DEF_LEN,
  parameter int                 LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_x,
  input  logic               i_x_vld,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pat,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_overlap_en,
  input  logic               i_cnt_clr,
  output logic               o_y,
  output logic [CNT_W-1:0]   o_match_cnt,
  output logic               o_cfg_err
);

  logic [MAX_LEN-1:0] r_hist, r_pat;
  logic [LEN_W-1:0]   r_fill, r_len;
  logic               r_y, r_cfg_err;

  logic [MAX_LEN-1:0] w_hist_n, w_hist_d, w_pat_d, w_mask;
  logic [LEN_W-1:0]   w_fill_n, w_fill_d, w_len_d;
  logic               w_cfg_legal, w_sample, w_match, w_cfg_err_d;

  assign w_cfg_legal = i_cfg_load && (i_cfg_len >= LEN_W'(2)) && (i_cfg_len <= LEN_W'(MAX_LEN));
  // A legal load discards any same-cycle sample; an illegal one lets it through.
  assign w_sample    = i_x_vld && !w_cfg_legal;
  assign w_hist_n    = {r_hist[MAX_LEN-2:0], i_x};
  assign w_fill_n    = (r_fill == r_len) ? r_len : (r_fill + LEN_W'(1));
  assign w_mask      = MAX_LEN'(len_mask(int'(r_len)));
  assign w_match     = w_sample && (w_fill_n == r_len) &&
                       (((w_hist_n ^ r_pat) & w_mask) == '0);

  always_comb begin
    w_hist_d    = r_hist;
    w_fill_d    = r_fill;
    w_pat_d     = r_pat;
    w_len_d     = r_len;
    w_cfg_err_d = r_cfg_err;
    if (w_cfg_legal) begin
      w_pat_d     = i_cfg_pat;
      w_len_d     = i_cfg_len;
      w_hist_d    = '0;
      w_fill_d    = '0;
      w_cfg_err_d = 1'b0;
    end else begin
      if (i_cfg_load) w_cfg_err_d = 1'b1;
      if (w_sample) begin
        w_hist_d = w_hist_n;
        w_fill_d = (w_match && !i_overlap_en) ? '0 : w_fill_n;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_hist    <= '0;
      r_fill    <= '0;
      r_pat     <= DEF_PAT;
      r_len     <= LEN_W'(DEF_LEN);
      r_y       <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_hist    <= w_hist_d;
      r_fill    <= w_fill_d;
      r_pat     <= w_pat_d;
      r_len     <= w_len_d;
      r_y       <= w_match;
      r_cfg_err <= w_cfg_err_d;
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (i_cnt_clr),
    .i_inc (w_match),
    .o_cnt (o_match_cnt)
  );

  assign o_y       = r_y;
  assign o_cfg_err = r_cfg_err;

endmodule
